// File: rtl/grid_router_tx_sched_if.sv
// Requester handshake and lane bundle between the packet sources and the
// link transmit scheduler.
interface grid_router_tx_sched_if;
    logic [3:0]  req;
    logic [67:0] dat;
    logic [3:0]  rdy;
    logic [5:0]  ig1;
    logic [5:0]  ig2;
    logic [5:0]  ig3;

    modport master (output req, dat, input rdy, ig1, ig2, ig3);
    modport slave  (input req, dat, output rdy, ig1, ig2, ig3);
endinterface

// File: rtl/grid_router_tx_sched.sv
// Round-robin packet scheduler for one grid router serial link: trains the
// link, frames whole packets into 18-bit words and drives the three lanes.
module grid_router_tx_sched #(
    parameter int unsigned pTrainLen = 64,
    parameter logic [15:0] pTrainPat = 16'hA5C3,
    parameter int unsigned pGap      = 2,
    parameter int unsigned pMaxLen   = 32
) (
    input  logic                         pclk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         retrain,
    grid_router_tx_sched_if.slave        link,
    output logic                         busy,
    output logic [1:0]                   gnt_id,
    output logic                         trunc
);
    localparam int unsigned LW = $clog2(pMaxLen + 1);

    typedef enum logic [2:0] {S_TRAIN, S_IDLE, S_SEND, S_EOPF, S_GAP} state_t;
    typedef enum logic [1:0] {T_FILL = 2'b00, T_SOP = 2'b01, T_DATA = 2'b10, T_EOP = 2'b11} wtype_t;

    state_t        state_q, state_d, post_eop;
    logic [7:0]    cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    gnt_q, gnt_d, rr_q, rr_d;
    logic [17:0]   word_q, word_d;
    logic          busy_q, busy_d, trunc_q, trunc_d, pend_q, pend_d, pend_eff;
    logic [3:0]    rdy_c;
    logic [2:0]    pick;
    logic [16:0]   words [4];

    for (genvar k = 0; k < 4; k++) begin : g_split
        assign words[k] = link.dat[k*17 +: 17];
    end

    // {found, index}: first set request at or after base, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            if (r[base + 2'(i)]) res = {1'b1, base + 2'(i)};
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        len_d    = len_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        word_d   = '0;
        busy_d   = 1'b1;
        trunc_d  = 1'b0;
        rdy_c    = '0;
        pend_eff = pend_q | retrain;
        pick     = rr_pick(link.req, rr_q);
        post_eop = (pGap == 0) ? (pend_eff ? S_TRAIN : S_IDLE) : S_GAP;

        unique case (state_q)
            S_TRAIN: begin
                word_d = {T_FILL, pTrainPat};
                if (cnt_q == 8'(pTrainLen - 1)) state_d = S_IDLE;
            end
            S_IDLE: begin
                busy_d = 1'b0;
                if (pend_eff) begin
                    state_d = S_TRAIN;
                end else if (en && pick[2]) begin
                    rdy_c[pick[1:0]] = 1'b1;
                    gnt_d   = pick[1:0];
                    rr_d    = pick[1:0] + 2'd1;
                    len_d   = LW'(1);
                    busy_d  = 1'b1;
                    word_d  = {T_SOP, words[pick[1:0]][15:0]};
                    // A one-word packet still opens with SOP; its EOP is synthesised next cycle.
                    state_d = words[pick[1:0]][16] ? S_EOPF : S_SEND;
                end
            end
            S_SEND: begin
                // Without req the packet stays open and a fill word goes out, not counted in len.
                if (link.req[gnt_q]) begin
                    rdy_c[gnt_q] = 1'b1;
                    len_d = len_q + LW'(1);
                    if (words[gnt_q][16] || (len_q + LW'(1) == LW'(pMaxLen))) begin
                        word_d  = {T_EOP, words[gnt_q][15:0]};
                        trunc_d = ~words[gnt_q][16];
                        state_d = post_eop;
                    end else begin
                        word_d = {T_DATA, words[gnt_q][15:0]};
                    end
                end
            end
            S_EOPF: begin
                word_d  = {T_EOP, 16'h0000};
                state_d = post_eop;
            end
            S_GAP: begin
                if (cnt_q == 8'(pGap - 1)) state_d = pend_eff ? S_TRAIN : S_IDLE;
            end
            default: state_d = S_TRAIN;
        endcase

        if (state_d != state_q) cnt_d = '0;
        pend_d = pend_eff & ~((state_d == S_TRAIN) && (state_q != S_TRAIN));
    end

    always_ff @(posedge pclk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= S_TRAIN;
            cnt_q   <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            rr_q    <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            trunc_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            trunc_q <= trunc_d;
            pend_q  <= pend_d;
        end
    end

    assign link.rdy = rdy_c;
    assign link.ig1 = word_q[5:0];
    assign link.ig2 = word_q[11:6];
    assign link.ig3 = word_q[17:12];
    assign busy     = busy_q;
    assign gnt_id   = gnt_q;
    assign trunc    = trunc_q;
endmodule

// File: doc/grid_router_tx_sched.md
Name: grid_router_tx_sched

Overview:
Per-link transmit scheduler for the grid router serial link. Arbitrates four packet requesters (N, E, S, W/local) round-robin, one whole packet per grant. Frames each packet into 18-bit link words and drives the three 6-bit lane inputs (ig1..ig3) that feed the GCR encoders and serialisers. Inserts link training after reset or on request, idle words, and inter-packet gaps.

Parameters:
pTrainLen, 64, number of training words sent after reset or retrain (1..255)
pTrainPat, 16'hA5C3, training word payload
pGap, 2, idle words inserted after every EOP (0..15)
pMaxLen, 32, maximum words per packet including SOP; longer packets are truncated

Ports:
pclk  in  1  parallel clock; sole clock
rst  in  1  synchronous active-low reset
en  in  1  link enable; when low, no new grant is issued
retrain  in  1  one-cycle pulse; starts training after the current packet ends
req  in  4  requester k has a valid word on dat[k]
dat  in  68  requester k word at dat[k*17+:17]: bit16 = last, bits15:0 = payload
rdy  out  4  one-hot; word on dat[k] accepted this cycle
ig1  out  6  lane 1 = word[5:0]
ig2  out  6  lane 2 = word[11:6]
ig3  out  6  lane 3 = word[17:12]
busy  out  1  high in TRAIN, SEND, or GAP
gnt_id  out  2  index of last/current granted requester
trunc  out  1  one-cycle pulse when a packet is truncated

Behaviour:
- Link word = {type[1:0], payload[15:0]}; type 00 idle/fill/train, 01 SOP, 10 data, 11 EOP. ig1..ig3 registered; new word each pclk.
- Reset (rst=0 at pclk edge): state=TRAIN, train count=0, word=idle (all lanes 0), rdy=0, busy=0, gnt_id=0, trunc=0, rr pointer=0. busy goes high the first cycle after reset is released.
- TRAIN: emit {00,pTrainPat} for exactly pTrainLen cycles, then IDLE. rdy=0.
- IDLE: emit {00,16'h0000}. If en=1 and any req, grant first set req starting from (gnt_id+1) mod 4 (after reset, search starts at 0). Same cycle: rdy[g]=1, go to SEND, len=1. SOP word appears on lanes next cycle (latency 1 from rdy).
- SEND: granted source only. req[g]=1: rdy[g]=1, emit {10,payload}, or {11,payload} if last=1. req[g]=0: rdy=0, emit fill {00,0}; packet stays open. Fill words do not count toward len.
- First accepted word always goes out as SOP, even with last=1. In that case the next cycle emits a forced {11,0000} without asserting rdy, then GAP.
- Truncation: the accepted word that brings len to pMaxLen goes out as EOP regardless of last. If that word's last=0, pulse trunc with it. Remaining source words are not consumed by this grant.
- GAP: emit pGap idle words, then TRAIN if a retrain is pending, else IDLE. pGap=0 goes straight to IDLE/TRAIN, so back-to-back arbitration is possible the cycle after EOP.
- retrain: latched into a pending flag. Acted on from IDLE immediately (next state TRAIN) or after GAP. Never interrupts SEND. Cleared on entering TRAIN.
- en=0 during SEND does not abort; the packet completes.
- Simultaneous req from several sources: round-robin as above; no source is granted twice while another waits.
- At most one rdy bit high in any cycle. rdy is never high outside SEND except the initial grant cycle in IDLE.

Test Plan:
- Reset release, pTrainLen=4 -> 4 cycles lanes {ig3,ig2,ig1}={00,A5C3}, then idle zeros; busy high for 4 cycles, then low; rdy=0 throughout.
- req=0001, words 1111,2222,3333(last) -> lanes 01_1111, 10_2222, 11_3333; rdy[0] pulses 3 cycles; 2 idle; gnt_id=0.
- All req held, 2-word packets -> grants in order 0,1,2,3,0, each separated by 2 gap words; rdy always one-hot.
- Granted source drops req for 3 cycles mid-packet -> 3 fill words {00,0000}; len unchanged; packet then completes with correct EOP.
- Single-word packet, last=1, payload BEEF -> 01_BEEF, then 11_0000 with rdy low, then gap.
- pMaxLen=4, 6-word packet -> 4th word sent as type 11 with trunc pulse; retrain pulsed mid-packet -> after gap, pTrainLen training words, then idle.
